bcd_counter_n: RTL and testbench
================================

Name: bcd_counter_n

Overview:
- Parametrised multi-digit BCD counter. Counts up or down, with synchronous clear, parallel load and optional saturation.
- Combinational terminal-count carry/borrow output, so instances cascade exactly like the single-digit decimal counter.
- Used for the display/timer chains driving the LED and 7-segment logic. It replaces hand-chained single-digit counters.

Parameters:
- DIGITS, 4, number of BCD digits (1..8); counter range 0 .. 10^DIGITS-1
- SATURATE, 0, 0 = wrap at the boundaries; 1 = hold at the boundary value instead of wrapping
- RST_VAL, 0, reset/clear value as an integer (0 .. 10^DIGITS-1), converted to BCD at elaboration

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- ena  input  1  count enable; one step per clk while high
- up_dn  input  1  1 = count up, 0 = count down
- clr  input  1  synchronous clear to RST_VAL
- load  input  1  synchronous parallel load of load_val
- load_val  input  4*DIGITS  BCD load value; digit i at bits [4i+3:4i]
- q  output  4*DIGITS  current BCD count; digit 0 = least significant
- c_out  output  1  terminal-count carry/borrow, combinational
- ovf  output  1  sticky overflow/underflow flag, registered

Behaviour:
- Reset (rst_n low, async): q = BCD(RST_VAL), ovf = 0. c_out follows the combinational rule below.
- Priority per rising edge: clr > load > ena. ena is ignored in any cycle where clr or load is high.
- clr: q <= BCD(RST_VAL); ovf <= 0.
- load: each nibble of load_val > 9 is clamped to 9 before storing (e.g. 4'hC loads as 9). ovf is unchanged.
- Count up (ena=1, up_dn=1):
  - digit 0 increments.
  - Digit i increments only when digits 0..i-1 are all 9; a digit at 9 that increments rolls to 0.
  - The whole value therefore steps by exactly +1 in BCD each enabled cycle.
- Count down (ena=1, up_dn=0): mirror of count up. Digit i decrements only when digits 0..i-1 are all 0; a digit at 0 that decrements rolls to 9.
- Terminal state: all 9s when counting up, all 0s when counting down.
- Boundary, SATURATE=0: all 9s + 1 -> all 0s; all 0s - 1 -> all 9s.
- Boundary, SATURATE=1: q holds at the terminal value.
- ovf <= 1 on any enabled count step taken from the terminal state, in both modes. It stays 1 until clr or reset; load does not clear it.
- c_out = ena & ~clr & ~load & (q is the terminal state for the current up_dn). No register delay, so cascaded ena chains remain single-cycle. c_out asserts in SATURATE mode as well.
- Direction change mid-count: takes effect on the same edge. No pipeline; latency is one clk from input to q.
- Reset mid-count: q returns to RST_VAL immediately and ovf clears. Counting resumes on the first enabled edge after rst_n deasserts.
- q must never hold a non-BCD nibble (a value > 9) in any reachable state.
- Width rules: all digit arithmetic is 4-bit per nibble. There is no binary adder across the full width.

Test Plan:
- Reset and up count (DIGITS=2, RST_VAL=0): hold rst_n low, then release with ena=1, up_dn=1 for 100 cycles.
  - q steps 00, 01 ... 09, 10 ... 99, then 00.
  - c_out is high only in the cycle where q=99; ovf=1 after the wrap.
- Down count and borrow (DIGITS=3): load 100 (12'h100), then count down 2 cycles.
  - q goes 099, then 098.
  - After loading 000, c_out=1 with ena=1, up_dn=0; the next edge gives q=999 and ovf=1.
- Saturate mode (SATURATE=1, DIGITS=2): load 98, then count up 4 cycles.
  - q reads 99, 99, 99, 99.
  - c_out stays high from the cycle q=99; ovf=1. q never reads 00.
- Priority and clamping:
  - clr, load and ena all high in the same cycle: q = RST_VAL and c_out=0.
  - load and ena high with load_val=8'hFA: q=99 (not 9A, not a count step).
- Direction flip and async reset:
  - Count up to 0457, then drive up_dn=0 for 3 cycles: q reads 0456, 0455, 0454.
  - Assert rst_n low between clock edges: q=RST_VAL and ovf=0 before the next edge.
- Cascade check: two DIGITS=1 instances chained, second ena = first c_out.
  - The pair reproduces the DIGITS=2 sequence 00..99 cycle-for-cycle over 200 cycles with random ena.

Source files
------------

// File: rtl/bcd_counter_n.sv
// Multi-digit BCD up/down counter with synchronous clear, clamped parallel load,
// optional saturation, combinational terminal-count carry/borrow and sticky overflow.
module bcd_counter_n #(
  parameter int DIGITS   = 4,
  parameter bit SATURATE = 1'b0,
  parameter int RST_VAL  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  up_dn,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   q,
  output logic                  c_out,
  output logic                  ovf
);

  localparam int W = 4 * DIGITS;

  function automatic logic [W-1:0] to_bcd(input int value);
    logic [W-1:0] r;
    int           v;
    r = '0;
    v = value;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  localparam logic [W-1:0] RST_BCD = to_bcd(RST_VAL);

  logic [W-1:0] q_q, q_d;
  logic         ovf_q, ovf_d;
  logic         all9, all0, terminal;
  logic [W-1:0] step_val;
  logic [W-1:0] load_clamped;
  logic         run_c;
  logic [3:0]   dig_c;

  always_comb begin
    all9 = 1'b1;
    all0 = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      all9 = all9 & (q_q[4*i +: 4] == 4'd9);
      all0 = all0 & (q_q[4*i +: 4] == 4'd0);
    end
  end

  assign terminal = up_dn ? all9 : all0;

  // Ripple the "all lower digits at their limit" condition nibble by nibble.
  always_comb begin
    step_val = q_q;
    run_c    = 1'b1;
    dig_c    = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      dig_c = q_q[4*i +: 4];
      if (run_c) begin
        if (up_dn) step_val[4*i +: 4] = (dig_c == 4'd9) ? 4'd0 : dig_c + 4'd1;
        else       step_val[4*i +: 4] = (dig_c == 4'd0) ? 4'd9 : dig_c - 4'd1;
      end
      run_c = run_c & (up_dn ? (dig_c == 4'd9) : (dig_c == 4'd0));
    end
  end

  always_comb begin
    load_clamped = load_val;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) load_clamped[4*i +: 4] = 4'd9;
    end
  end

  always_comb begin
    q_d   = q_q;
    ovf_d = ovf_q;
    if (clr) begin
      q_d   = RST_BCD;
      ovf_d = 1'b0;
    end else if (load) begin
      q_d = load_clamped;
    end else if (ena) begin
      if (terminal) ovf_d = 1'b1;
      if (!(SATURATE && terminal)) q_d = step_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q   <= RST_BCD;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
    end
  end

  assign q     = q_q;
  assign ovf   = ovf_q;
  assign c_out = ena & ~clr & ~load & terminal;

endmodule

// File: tb/tb_bcd_counter_n.sv
// Directed bench for bcd_counter_n: several parameterisations side by side plus a
// two-instance single-digit cascade checked against a decimal model.
module tb_bcd_counter_n;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] bcd(input int value);
    logic [31:0] r;
    int          v;
    r = '0;
    v = value;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // u2: DIGITS=2 wrap, RST_VAL=0
  logic ena2, up2, clr2, ld2, c2, o2;
  logic [7:0] lv2, q2;
  // u3: DIGITS=3 wrap, RST_VAL=37
  logic ena3, up3, clr3, ld3, c3, o3;
  logic [11:0] lv3, q3;
  // us: DIGITS=2 saturating
  logic enas, ups, clrs, lds, cs, os;
  logic [7:0] lvs, qs;
  // u4: DIGITS=4 wrap
  logic ena4, up4, clr4, ld4, c4, o4;
  logic [15:0] lv4, q4;
  // cascade: two single-digit counters
  logic ea, ca_c, cb_c, oa, ob;
  logic [3:0] qa, qb;

  bcd_counter_n #(.DIGITS(2), .SATURATE(1'b0), .RST_VAL(0)) u2 (
    .clk(clk), .rst_n(rst_n), .ena(ena2), .up_dn(up2), .clr(clr2), .load(ld2),
    .load_val(lv2), .q(q2), .c_out(c2), .ovf(o2));

  bcd_counter_n #(.DIGITS(3), .SATURATE(1'b0), .RST_VAL(37)) u3 (
    .clk(clk), .rst_n(rst_n), .ena(ena3), .up_dn(up3), .clr(clr3), .load(ld3),
    .load_val(lv3), .q(q3), .c_out(c3), .ovf(o3));

  bcd_counter_n #(.DIGITS(2), .SATURATE(1'b1), .RST_VAL(0)) us (
    .clk(clk), .rst_n(rst_n), .ena(enas), .up_dn(ups), .clr(clrs), .load(lds),
    .load_val(lvs), .q(qs), .c_out(cs), .ovf(os));

  bcd_counter_n #(.DIGITS(4), .SATURATE(1'b0), .RST_VAL(0)) u4 (
    .clk(clk), .rst_n(rst_n), .ena(ena4), .up_dn(up4), .clr(clr4), .load(ld4),
    .load_val(lv4), .q(q4), .c_out(c4), .ovf(o4));

  bcd_counter_n #(.DIGITS(1), .SATURATE(1'b0), .RST_VAL(0)) ua (
    .clk(clk), .rst_n(rst_n), .ena(ea), .up_dn(1'b1), .clr(1'b0), .load(1'b0),
    .load_val(4'h0), .q(qa), .c_out(ca_c), .ovf(oa));

  bcd_counter_n #(.DIGITS(1), .SATURATE(1'b0), .RST_VAL(0)) ub (
    .clk(clk), .rst_n(rst_n), .ena(ca_c), .up_dn(1'b1), .clr(1'b0), .load(1'b0),
    .load_val(4'h0), .q(qb), .c_out(cb_c), .ovf(ob));

  logic [15:0] down_exp [3];
  int m;

  initial begin
    rst_n = 1'b0;
    {ena2, up2, clr2, ld2} = '0; lv2 = '0;
    {ena3, up3, clr3, ld3} = '0; lv3 = '0;
    {enas, ups, clrs, lds} = '0; lvs = '0;
    {ena4, up4, clr4, ld4} = '0; lv4 = '0;
    ea = 1'b0;
    down_exp[0] = 16'h0456; down_exp[1] = 16'h0455; down_exp[2] = 16'h0454;

    // Reset values
    tick; tick;
    check("rst_q2", q2, 8'h00);
    check("rst_o2", o2, 1'b0);
    check("rst_c2", c2, 1'b0);
    check("rst_q3", q3, 12'h037);
    check("rst_q4", q4, 16'h0000);

    // Up count 00..99 then wrap
    rst_n = 1'b1;
    ena2 = 1'b1; up2 = 1'b1;
    for (int k = 0; k < 100; k++) begin
      #1;
      check("up_q2", q2, bcd(k));
      check("up_c2", c2, (k == 99) ? 1 : 0);
      check("up_o2_pre", o2, 1'b0);
      tick;
    end
    check("wrap_q2", q2, 8'h00);
    check("wrap_o2", o2, 1'b1);

    // Clamped load with ena also high; ovf survives load
    ld2 = 1'b1; lv2 = 8'hFA;
    #1;
    check("ld_c2", c2, 1'b0);
    tick;
    check("clamp_q2", q2, 8'h99);
    check("ld_keeps_o2", o2, 1'b1);
    ld2 = 1'b0; ena2 = 1'b0;

    // Down count and borrow
    ld3 = 1'b1; lv3 = 12'h100;
    tick;
    check("ld_q3", q3, 12'h100);
    ld3 = 1'b0; ena3 = 1'b1; up3 = 1'b0;
    tick;
    check("dn1_q3", q3, 12'h099);
    tick;
    check("dn2_q3", q3, 12'h098);
    ena3 = 1'b0; ld3 = 1'b1; lv3 = 12'h000;
    tick;
    ld3 = 1'b0; ena3 = 1'b1;
    #1;
    check("borrow_c3", c3, 1'b1);
    check("borrow_o3_pre", o3, 1'b0);
    tick;
    check("borrow_q3", q3, 12'h999);
    check("borrow_o3", o3, 1'b1);

    // clr > load > ena
    clr3 = 1'b1; ld3 = 1'b1; ena3 = 1'b1; lv3 = 12'h555;
    #1;
    check("prio_c3", c3, 1'b0);
    tick;
    check("prio_q3", q3, 12'h037);
    check("prio_o3", o3, 1'b0);
    clr3 = 1'b0; ena3 = 1'b0; lv3 = 12'hC3B;
    tick;
    check("clamp_q3", q3, 12'h939);
    ld3 = 1'b0;

    // Saturate up
    lds = 1'b1; lvs = 8'h98;
    tick;
    lds = 1'b0; enas = 1'b1; ups = 1'b1;
    #1;
    check("sat_c_pre", cs, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick;
      check("sat_q", qs, 8'h99);
      check("sat_c", cs, 1'b1);
    end
    check("sat_o", os, 1'b1);
    // Saturate down
    enas = 1'b0; ups = 1'b0; lds = 1'b1; lvs = 8'h00;
    tick;
    lds = 1'b0; enas = 1'b1;
    tick;
    check("satdn_q", qs, 8'h00);
    check("satdn_c", cs, 1'b1);
    enas = 1'b0;

    // Direction flip
    ld4 = 1'b1; lv4 = 16'h0450;
    tick;
    ld4 = 1'b0; ena4 = 1'b1; up4 = 1'b1;
    repeat (7) tick;
    check("up_q4", q4, 16'h0457);
    up4 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick;
      check("flip_q4", q4, down_exp[k]);
    end
    // Multi-digit carry and borrow ripple
    ena4 = 1'b0; ld4 = 1'b1; lv4 = 16'h0999;
    tick;
    ld4 = 1'b0; ena4 = 1'b1; up4 = 1'b1;
    tick;
    check("carry_q4", q4, 16'h1000);
    up4 = 1'b0;
    tick;
    check("borrow_q4", q4, 16'h0999);
    check("borrow_o4", o4, 1'b0);
    ena4 = 1'b0;

    // Async reset between edges
    #3 rst_n = 1'b0;
    #1;
    check("arst_q4", q4, 16'h0000);
    check("arst_q3", q3, 12'h037);
    check("arst_o2", o2, 1'b0);
    check("arst_o3", o3, 1'b0);
    #1 rst_n = 1'b1;
    ena4 = 1'b1; up4 = 1'b1;
    tick;
    check("resume_q4", q4, 16'h0001);
    ena4 = 1'b0;

    // Cascade against a decimal model
    m = 0;
    for (int k = 0; k < 200; k++) begin
      ea = 1'($urandom_range(0, 1));
      #1;
      check("casc_q", {qb, qa}, bcd(m));
      tick;
      if (ea) m = (m + 1) % 100;
    end
    ea = 1'b0;
    #1;
    check("casc_final", {qb, qa}, bcd(m));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
